vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Raster timing generator for 640x480@60 on a 25.175 MHz pixel clock.
- Produces the colPos/rowPos pixel coordinates consumed by the pixel-colour generators (UI/text overlay, playfield renderer).
- Takes their combinational 6-bit colour back and emits registered, blanked RGB plus hsync/vsync to the DAC/connector.
- Also issues a once-per-frame tick for game-logic timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync (0 = active-low)
- COLOR_W, 6, colour width (RRGGBB)

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- colPos  out  10  current horizontal counter, 0..H_TOTAL-1
- rowPos  out  10  current vertical counter, 0..V_TOTAL-1
- active  out  1  high when colPos<H_ACTIVE and rowPos<V_ACTIVE (combinational from counters)
- color_in  in  COLOR_W  colour for (colPos,rowPos), returned combinationally by the generators in the same cycle
- rgb_out  out  COLOR_W  registered pixel colour to DAC
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- frame_tick  out  1  one-cycle pulse at start of vertical blank

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both counters are 10-bit and must not overflow at defaults.
- Counters h_cnt and v_cnt drive colPos and rowPos directly with no extra register.
  - h_cnt increments every clock; at H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt at V_TOTAL-1 together with h_cnt at H_TOTAL-1 wraps both to 0.
  - Frame period = 420000 clocks.
- Stage 1 is the counters; stage 2 is the output registers. rgb_out, hsync and vsync all lag colPos/rowPos by exactly 1 clock and are mutually aligned.
- rgb_out <= active ? color_in : 0. Blanking is forced black regardless of color_in.
- hsync <= SYNC_ACTIVE when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else ~SYNC_ACTIVE.
- vsync <= SYNC_ACTIVE when v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else ~SYNC_ACTIVE. vsync spans whole lines, aligned to the h_cnt=0 boundary.
- frame_tick <= 1 for one clock when counters are (H_TOTAL-1, V_ACTIVE-1). It is therefore high exactly during the cycle the counters read (0, V_ACTIVE), once per frame.
- Reset (rst_n low, asynchronous):
  - h_cnt=0, v_cnt=0, rgb_out=0, hsync=vsync=~SYNC_ACTIVE, frame_tick=0.
  - active=1 combinationally because the counters are (0,0).
- Reset mid-frame: everything clears immediately with no partial-frame completion. The first clock after release advances to (1,0). The first rgb_out after release reflects color_in at (0,0).
- color_in is sampled only through the stage-2 register. Its value during blanking is ignored.
- No external enable: the block free-runs from reset release.

Test Plan:
- Reset values: hold rst_n=0, then release. Require colPos=0, rowPos=0, active=1, rgb_out=0, hsync=vsync=1, frame_tick=0. After 1 clock, colPos=1 and rgb_out=color_in sampled at (0,0).
- Line timing: run 2 lines.
  - colPos wraps 799->0 with rowPos 0->1 on the same edge.
  - hsync low for exactly 96 clocks, starting 1 clock after colPos=656.
  - active low for colPos 640..799.
- Frame timing: run 2 full frames.
  - 420000 clocks between rowPos=0/colPos=0 occurrences.
  - vsync low for exactly 1600 clocks, starting 1 clock after (0,490).
  - frame_tick high exactly once per frame, at counters (0,480).
- Blanking: drive color_in=6'b110000 constantly. rgb_out=6'b110000 for every cycle whose previous-cycle counters were active, and rgb_out=0 otherwise (640x480=307200 red pixels per frame).
- Pipeline alignment: drive color_in=colPos[5:0]. At every active cycle, rgb_out equals (previous colPos)[5:0].
- Mid-frame reset: assert rst_n=0 asynchronously at (300,200) between clock edges.
  - All outputs reach reset values immediately, without waiting for a clock edge.
  - After release, frame timing matches the Frame timing scenario, with no spurious frame_tick.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster interface between the timing generator and the
// pixel-colour generators / DAC path.
//   colPos, rowPos : current raster counters (timing generator -> generators)
//   active         : visible-area flag for the current counters
//   color_in       : combinational colour for (colPos,rowPos) (generators -> timing)
//   rgb_out        : registered, blanked pixel colour to the DAC
//   hsync, vsync   : registered sync pulses to the connector
//   frame_tick     : one-cycle pulse at the start of vertical blank
// master = timing generator, slave = colour generators / downstream consumers.
interface vga_timing_if #(
  parameter int COLOR_W = 6
);
  logic [9:0]         colPos;
  logic [9:0]         rowPos;
  logic               active;
  logic [COLOR_W-1:0] color_in;
  logic [COLOR_W-1:0] rgb_out;
  logic               hsync;
  logic               vsync;
  logic               frame_tick;

  modport master (
    output colPos, rowPos, active, rgb_out, hsync, vsync, frame_tick,
    input  color_in
  );

  modport slave (
    input  colPos, rowPos, active, rgb_out, hsync, vsync, frame_tick,
    output color_in
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator (640x480@60 by default).
// Ports:
//   clk    : pixel clock, everything on the rising edge
//   rst_n  : asynchronous active-low reset
//   vif    : vga_timing_if master modport (counters, active, colour return,
//            registered rgb/hsync/vsync and frame_tick)
// The raster counters drive colPos/rowPos directly; rgb_out, hsync, vsync and
// frame_tick are registered one clock behind the counters so the colour
// returned combinationally by the generators lines up with its own syncs.
module vga_timing #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   COLOR_W     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_timing_if.master  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_TICK   = 10'(V_ACTIVE - 1);

  logic [9:0]         h_cnt_p0;
  logic [9:0]         v_cnt_p0;
  logic               active_p0;
  logic               h_wrap_p0;

  logic [COLOR_W-1:0] rgb_p1;
  logic               hsync_p1;
  logic               vsync_p1;
  logic               frame_tick_p1;

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  // Blanking forces black whatever the generators return outside the visible area.
  function automatic logic [COLOR_W-1:0] blank_color(input logic             vis,
                                                     input logic [COLOR_W-1:0] c);
    return vis ? c : '0;
  endfunction

  assign active_p0 = (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
  assign h_wrap_p0 = (h_cnt_p0 == H_LAST);

  // ---- stage 1: raster counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else begin
      if (h_wrap_p0) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 10'd0 : v_cnt_p0 + 10'd1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 10'd1;
      end
    end
  end

  // ---- stage 2: output registers ----
  // vsync is decoded from v_cnt alone, so it changes only when v_cnt does,
  // i.e. aligned to the h_cnt=0 boundary and spanning whole lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p1        <= '0;
      hsync_p1      <= ~SYNC_ACTIVE;
      vsync_p1      <= ~SYNC_ACTIVE;
      frame_tick_p1 <= 1'b0;
    end else begin
      rgb_p1        <= blank_color(active_p0, vif.color_in);
      hsync_p1      <= in_window(h_cnt_p0, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_p1      <= in_window(v_cnt_p0, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // Registered on the last pixel of the last visible line so it is high
      // while the counters read (0, V_ACTIVE).
      frame_tick_p1 <= h_wrap_p0 && (v_cnt_p0 == V_TICK);
    end
  end

  assign vif.colPos     = h_cnt_p0;
  assign vif.rowPos     = v_cnt_p0;
  assign vif.active     = active_p0;
  assign vif.rgb_out    = rgb_p1;
  assign vif.hsync      = hsync_p1;
  assign vif.vsync      = vsync_p1;
  assign vif.frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       act;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int         n;
    logic [5:0] c;
    exp_t       e;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [5:0] color_val;
  logic align_mode;

  vga_timing_if #(.COLOR_W(6)) vif_d ();
  vga_timing_if #(.COLOR_W(6)) vif_s ();

  assign vif_d.color_in = align_mode ? vif_d.colPos[5:0] : color_val;
  assign vif_s.color_in = align_mode ? vif_s.colPos[5:0] : color_val;

  vga_timing dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif_d)
  );

  // Shrunken raster so whole frames fit in a short run.
  vga_timing #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .SYNC_ACTIVE(1'b0), .COLOR_W(6)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nchecks = 0;
  int   nerr    = 0;
  int   cyc     = 0;
  cfg_t cfg_d, cfg_s;
  int   md_h = 0, md_v = 0, ms_h = 0, ms_v = 0;
  exp_t q_d[$];
  exp_t q_s[$];

  logic measure = 1'b0;
  int   s_hs_low, s_vs_low, s_ft, s_red, d_run, s_run;
  int   zero_hits[$];

  function automatic exp_t mk(input int col, input int row, input logic act,
                              input logic [5:0] rgb, input logic hs,
                              input logic vs, input logic ft);
    exp_t e;
    e.col = 10'(col); e.row = 10'(row); e.act = act; e.rgb = rgb;
    e.hs = hs; e.vs = vs; e.ft = ft;
    return e;
  endfunction

  function automatic exp_t get_d();
    return mk(int'(vif_d.colPos), int'(vif_d.rowPos), vif_d.active, vif_d.rgb_out,
              vif_d.hsync, vif_d.vsync, vif_d.frame_tick);
  endfunction

  function automatic exp_t get_s();
    return mk(int'(vif_s.colPos), int'(vif_s.rowPos), vif_s.active, vif_s.rgb_out,
              vif_s.hsync, vif_s.vsync, vif_s.frame_tick);
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got col=%0d row=%0d act=%b rgb=%h hs=%b vs=%b ft=%b, want col=%0d row=%0d act=%b rgb=%h hs=%b vs=%b ft=%b",
               name, cyc, got.col, got.row, got.act, got.rgb, got.hs, got.vs, got.ft,
               want.col, want.row, want.act, want.rgb, want.hs, want.vs, want.ft);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    nchecks++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Behavioural raster model: expected outputs one edge after counters (h,v).
  task automatic predict(input cfg_t c, inout int h, inout int v,
                         input logic [5:0] colr, output exp_t e);
    int ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (!rst_n) begin
      h = 0; v = 0;
      e = mk(0, 0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
    end else begin
      e.rgb = (h < c.ha && v < c.va) ? colr : 6'd0;
      e.hs  = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hs);
      e.vs  = !(v >= c.va + c.vf && v < c.va + c.vf + c.vs);
      e.ft  = (h == ht - 1) && (v == c.va - 1);
      if (h == ht - 1) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
      e.col = 10'(h); e.row = 10'(v);
      e.act = (h < c.ha) && (v < c.va);
    end
  endtask

  task automatic tick();
    exp_t e, got;
    logic [5:0] cd, cs;
    cd = align_mode ? 6'(md_h) : color_val;
    cs = align_mode ? 6'(ms_h) : color_val;
    predict(cfg_d, md_h, md_v, cd, e); q_d.push_back(e);
    predict(cfg_s, ms_h, ms_v, cs, e); q_s.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = get_d(); check("sb_default", got, q_d.pop_front());
    got = get_s(); check("sb_small", got, q_s.pop_front());
    if (measure) begin
      if (!vif_s.hsync) s_hs_low++;
      if (!vif_s.vsync) s_vs_low++;
      if (vif_s.frame_tick) s_ft++;
      if (vif_s.rgb_out == 6'b110000) s_red++;
      if (vif_s.colPos == 10'd0 && vif_s.rowPos == 10'd0) zero_hits.push_back(cyc);
      if (!vif_d.hsync) d_run++;
      else if (d_run != 0) begin check_int("hsync_width_default", d_run, 96); d_run = 0; end
      if (!vif_s.hsync) s_run++;
      else if (s_run != 0) begin check_int("hsync_width_small", s_run, 6); s_run = 0; end
    end
  endtask

  task automatic clear_stats();
    s_hs_low = 0; s_vs_low = 0; s_ft = 0; s_red = 0; d_run = 0; s_run = 0;
    zero_hits.delete();
  endtask

  task automatic frame_window(input string tag);
    clear_stats();
    measure = 1'b1;
    repeat (4480) tick();
    measure = 1'b0;
    check_int({tag, "_vsync_low"}, s_vs_low, 2 * 2 * 56);
    check_int({tag, "_hsync_low"}, s_hs_low, 2 * 40 * 6);
    check_int({tag, "_frame_ticks"}, s_ft, 2);
    check_int({tag, "_red_pixels"}, s_red, 2 * 40 * 30);
    check_int({tag, "_frame_starts"}, zero_hits.size(), 2);
    if (zero_hits.size() == 2)
      check_int({tag, "_frame_period"}, zero_hits[1] - zero_hits[0], 2240);
  endtask

  vec_t tbl[11];
  exp_t rst_val;

  initial begin
    cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33};
    cfg_s = '{40, 4, 6, 6, 30, 3, 2, 5};
    rst_val = mk(0, 0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0);

    tbl[0]  = '{0,   6'h15, mk(0,   0, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[1]  = '{1,   6'h2A, mk(1,   0, 1'b1, 6'h2A, 1'b1, 1'b1, 1'b0)};
    tbl[2]  = '{640, 6'h11, mk(640, 0, 1'b0, 6'h11, 1'b1, 1'b1, 1'b0)};
    tbl[3]  = '{641, 6'h22, mk(641, 0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[4]  = '{656, 6'h3F, mk(656, 0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[5]  = '{657, 6'h3F, mk(657, 0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0)};
    tbl[6]  = '{752, 6'h3F, mk(752, 0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0)};
    tbl[7]  = '{753, 6'h3F, mk(753, 0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[8]  = '{799, 6'h3F, mk(799, 0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[9]  = '{800, 6'h30, mk(0,   1, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0)};
    tbl[10] = '{801, 6'h30, mk(1,   1, 1'b1, 6'h30, 1'b1, 1'b1, 1'b0)};

    rst_n = 1'b0;
    color_val = 6'h00;
    align_mode = 1'b0;
    clear_stats();

    // Reset held across edges, then released between edges.
    repeat (3) tick();
    check("reset_default", get_d(), rst_val);
    check("reset_small", get_s(), rst_val);
    #3 rst_n = 1'b1;
    cyc = 0;

    // Line landmarks on the default raster.
    for (int i = 0; i < 11; i++) begin
      color_val = tbl[i].c;
      while (cyc < tbl[i].n) tick();
      check($sformatf("vec%0d_n%0d", i, tbl[i].n), get_d(), tbl[i].e);
    end

    // Two full frames of the small raster with constant red.
    rst_n = 1'b0;
    repeat (2) tick();
    #3 rst_n = 1'b1;
    cyc = 0;
    color_val = 6'b110000;
    frame_window("frames");

    // Colour follows colPos: checks rgb_out lags the counters by one clock.
    align_mode = 1'b1;
    repeat (1500) tick();
    align_mode = 1'b0;

    // Asynchronous reset in the middle of a frame.
    begin
      int guard = 0;
      while (!(ms_h == 20 && ms_v == 20) && guard < 5000) begin
        tick();
        guard++;
      end
      if (guard >= 5000) begin
        nchecks++; nerr++;
        $display("FAIL midframe_wait: got timeout want small raster at (20,20)");
      end
    end
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_default", get_d(), rst_val);
    check("async_reset_small", get_s(), rst_val);
    repeat (3) tick();
    #3 rst_n = 1'b1;
    cyc = 0;
    frame_window("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
